// File: rtl/tank_pkg.sv
// Shared keycode constants, arbiter state encoding and move-key classifiers
// for the two-player tank input path.
package tank_pkg;

    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_ENTER = 8'h28;

    typedef enum logic [1:0] {IDLE, SNAP, SCAN, COMMIT} arb_state_t;

    function automatic logic is_p1_move(input logic [7:0] kc);
        return (kc == KC_W) || (kc == KC_A) || (kc == KC_S) || (kc == KC_D);
    endfunction

    function automatic logic is_p2_move(input logic [7:0] kc);
        return (kc == KC_LEFT) || (kc == KC_RIGHT) || (kc == KC_DOWN) || (kc == KC_UP);
    endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the vsync-derived frame tick into the Clk domain and turns its
// rising edge into a single-cycle pulse.
module frame_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic sync_prev_q, sync_prev_d;

    always_comb begin
        meta_d      = async_in;
        sync_d      = meta_q;
        sync_prev_d = sync_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
        end
    end

    assign pulse = sync_q & ~sync_prev_q;

endmodule

// File: rtl/tank_input_arbiter.sv
// Once per frame, snapshots the shared keyboard report, scans it one slot per
// cycle and commits one sticky move key plus a rate-limited fire strobe per player.
module tank_input_arbiter
    import tank_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int CD_W            = 5
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [8*NUM_SLOTS-1:0] keycodes,
    output logic [7:0]             keycode_p1,
    output logic [7:0]             keycode_p2,
    output logic                   fire_p1,
    output logic                   fire_p2,
    output logic                   busy,
    output logic                   frame_overrun
);

    localparam int              SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_FRAMES);

    logic frame_start;

    frame_edge_sync u_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (frame_clk),
        .pulse    (frame_start)
    );

    arb_state_t              state_q, state_d;
    logic [SLOT_W-1:0]       cnt_q, cnt_d;
    logic [8*NUM_SLOTS-1:0]  snap_q, snap_d;
    logic [8*NUM_SLOTS-1:0]  prev_snap_q, prev_snap_d;
    logic                    p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic [7:0]              p1_first_q, p1_first_d, p2_first_q, p2_first_d;
    logic [7:0]              prev_p1_q, prev_p1_d, prev_p2_q, prev_p2_d;
    logic [7:0]              kc_p1_q, kc_p1_d, kc_p2_q, kc_p2_d;
    logic                    fire_p1_q, fire_p1_d, fire_p2_q, fire_p2_d;
    logic [CD_W-1:0]         cd_p1_q, cd_p1_d, cd_p2_q, cd_p2_d;
    logic                    overrun_q, overrun_d;

    // Fire-key presence in the current and previous snapshots, per slot.
    logic [NUM_SLOTS-1:0] space_now, space_prev, enter_now, enter_prev;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign space_now[gi]  = (snap_q[8*gi +: 8]      == KC_SPACE);
            assign space_prev[gi] = (prev_snap_q[8*gi +: 8] == KC_SPACE);
            assign enter_now[gi]  = (snap_q[8*gi +: 8]      == KC_ENTER);
            assign enter_prev[gi] = (prev_snap_q[8*gi +: 8] == KC_ENTER);
        end
    endgenerate

    logic       space_new, enter_new;
    logic [7:0] cur_slot;
    logic [7:0] win_p1, win_p2;

    assign space_new = (|space_now) & ~(|space_prev);
    assign enter_new = (|enter_now) & ~(|enter_prev);
    assign cur_slot  = snap_q[{cnt_q, 3'b000} +: 8];
    assign win_p1    = p1_hit_q ? prev_p1_q : p1_first_q;
    assign win_p2    = p2_hit_q ? prev_p2_q : p2_first_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        prev_snap_d = prev_snap_q;
        p1_hit_d    = p1_hit_q;
        p2_hit_d    = p2_hit_q;
        p1_first_d  = p1_first_q;
        p2_first_d  = p2_first_q;
        prev_p1_d   = prev_p1_q;
        prev_p2_d   = prev_p2_q;
        kc_p1_d     = kc_p1_q;
        kc_p2_d     = kc_p2_q;
        fire_p1_d   = 1'b0;
        fire_p2_d   = 1'b0;
        cd_p1_d     = cd_p1_q;
        cd_p2_d     = cd_p2_q;
        overrun_d   = overrun_q | (frame_start && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (frame_start) state_d = SNAP;
            end
            SNAP: begin
                snap_d     = keycodes;
                p1_hit_d   = 1'b0;
                p2_hit_d   = 1'b0;
                p1_first_d = 8'h00;
                p2_first_d = 8'h00;
                cnt_d      = '0;
                state_d    = SCAN;
            end
            SCAN: begin
                if ((prev_p1_q != 8'h00) && (cur_slot == prev_p1_q)) p1_hit_d = 1'b1;
                if ((prev_p2_q != 8'h00) && (cur_slot == prev_p2_q)) p2_hit_d = 1'b1;
                if ((p1_first_q == 8'h00) && is_p1_move(cur_slot)) p1_first_d = cur_slot;
                if ((p2_first_q == 8'h00) && is_p2_move(cur_slot)) p2_first_d = cur_slot;
                if (cnt_q == LAST_SLOT) begin
                    // Strobes are prepared here so they are high during COMMIT itself.
                    fire_p1_d = space_new && (cd_p1_q == '0);
                    fire_p2_d = enter_new && (cd_p2_q == '0);
                    state_d   = COMMIT;
                end else begin
                    cnt_d = cnt_q + SLOT_W'(1);
                end
            end
            COMMIT: begin
                kc_p1_d     = win_p1;
                kc_p2_d     = win_p2;
                prev_p1_d   = win_p1;
                prev_p2_d   = win_p2;
                prev_snap_d = snap_q;
                if (fire_p1_q)            cd_p1_d = CD_LOAD;
                else if (cd_p1_q != '0)   cd_p1_d = cd_p1_q - CD_W'(1);
                if (fire_p2_q)            cd_p2_d = CD_LOAD;
                else if (cd_p2_q != '0)   cd_p2_d = cd_p2_q - CD_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            prev_snap_q <= '0;
            p1_hit_q    <= 1'b0;
            p2_hit_q    <= 1'b0;
            p1_first_q  <= 8'h00;
            p2_first_q  <= 8'h00;
            prev_p1_q   <= 8'h00;
            prev_p2_q   <= 8'h00;
            kc_p1_q     <= 8'h00;
            kc_p2_q     <= 8'h00;
            fire_p1_q   <= 1'b0;
            fire_p2_q   <= 1'b0;
            cd_p1_q     <= '0;
            cd_p2_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            prev_snap_q <= prev_snap_d;
            p1_hit_q    <= p1_hit_d;
            p2_hit_q    <= p2_hit_d;
            p1_first_q  <= p1_first_d;
            p2_first_q  <= p2_first_d;
            prev_p1_q   <= prev_p1_d;
            prev_p2_q   <= prev_p2_d;
            kc_p1_q     <= kc_p1_d;
            kc_p2_q     <= kc_p2_d;
            fire_p1_q   <= fire_p1_d;
            fire_p2_q   <= fire_p2_d;
            cd_p1_q     <= cd_p1_d;
            cd_p2_q     <= cd_p2_d;
            overrun_q   <= overrun_d;
        end
    end

    assign keycode_p1    = kc_p1_q;
    assign keycode_p2    = kc_p2_q;
    assign fire_p1       = fire_p1_q;
    assign fire_p2       = fire_p2_q;
    assign busy          = (state_q != IDLE);
    assign frame_overrun = overrun_q;

endmodule
